// File: rtl/node_rx_fifo.sv
// -----------------------------------------------------------------------------
// node_rx_fifo
// Receive buffer for one output port of the 4-node round-robin distributor.
// Every single-cycle valid pulse from the distributor is captured into a small
// show-ahead FIFO, tagged with the node it originated from, and offered to the
// local consumer over a valid/ready handshake.
//
// Parameters
//   data_len : data word width
//   DEPTH    : FIFO entries (power of 2, >= 2)
//   ADDR     : log2(DEPTH)
//   NODE_ID  : distributor output port (0..3) this instance is attached to
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   din       in   data word from distributor doutN
//   inv       in   valid pulse from distributor outvN
//   dout      out  head-of-FIFO data (show-ahead)
//   dout_src  out  source node ID of the head word
//   outv      out  head word valid (FIFO not empty)
//   ready     in   consumer accepts the head word this cycle
//   count     out  number of stored words, 0..DEPTH
//   full      out  count == DEPTH
//   empty     out  count == 0
//   overflow  out  sticky: a word was dropped because the FIFO was full
//   self_err  out  sticky: a word arrived in this node's own slot
//   clr_flags in   synchronous clear of overflow and self_err
// -----------------------------------------------------------------------------
module node_rx_fifo #(
   parameter int unsigned data_len = 8,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR     = 2,
   parameter int unsigned NODE_ID  = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [data_len-1:0] din,
   input  logic                inv,
   output logic [data_len-1:0] dout,
   output logic [1:0]          dout_src,
   output logic                outv,
   input  logic                ready,
   output logic [ADDR:0]       count,
   output logic                full,
   output logic                empty,
   output logic                overflow,
   output logic                self_err,
   input  logic                clr_flags
);

   localparam logic [1:0]    LP_NODE = 2'(NODE_ID);
   localparam logic [ADDR:0] LP_FULL = (ADDR+1)'(DEPTH);

   // Each entry holds {source node, data}
   logic [data_len+1:0] r_mem [DEPTH];
   logic [ADDR-1:0]     r_wr_ptr;
   logic [ADDR-1:0]     r_rd_ptr;
   logic [ADDR:0]       r_count;
   logic [1:0]          r_slot;
   logic                r_overflow;
   logic                r_self_err;

   logic [1:0]          w_src;
   logic                w_full;
   logic                w_empty;
   logic                w_pop;
   logic                w_self;
   logic                w_accept;
   logic                w_push;
   logic                w_drop;

   // The distributor registers its output one cycle after serving slot k-1,
   // so a word seen while the slot counter reads k belongs to node k-1.
   assign w_src    = r_slot - 2'd1;

   assign w_full   = (r_count == LP_FULL);
   assign w_empty  = (r_count == '0);

   // No bypass: a pop needs a word that was already stored before this edge.
   assign w_pop    = ~w_empty & ready;
   assign w_self   = inv & (w_src == LP_NODE);
   assign w_accept = inv & ~w_self;
   // A full FIFO still takes a word when the head leaves on the same edge.
   assign w_push   = w_accept & (~w_full | w_pop);
   assign w_drop   = w_accept & w_full & ~w_pop;

   // Slot counter, kept in lock-step with the distributor state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_slot <= '0;
      end else begin
         r_slot <= r_slot + 2'd1;
      end
   end

   // Storage is cleared on reset so that dout/dout_src read zero afterwards
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wr_ptr] <= {w_src, din};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (ADDR+1)'(1);
            2'b01:   r_count <= r_count - (ADDR+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky flags: a set event on the same edge as clr_flags wins
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overflow <= 1'b0;
         r_self_err <= 1'b0;
      end else begin
         r_overflow <= w_drop | (r_overflow & ~clr_flags);
         r_self_err <= (inv & w_self) | (r_self_err & ~clr_flags);
      end
   end

   assign dout     = r_mem[r_rd_ptr][data_len-1:0];
   assign dout_src = r_mem[r_rd_ptr][data_len+1:data_len];
   assign outv     = ~w_empty;
   assign count    = r_count;
   assign full     = w_full;
   assign empty    = w_empty;
   assign overflow = r_overflow;
   assign self_err = r_self_err;

endmodule

// File: tb/tb_node_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_node_rx_fifo
// One instance per distributor port (NODE_ID 0..3) shares the same stimulus.
// A queue-based reference model tracks each instance; directed vectors with
// hand-derived expectations cover the listed corner cases, then random
// traffic runs against the model.
// -----------------------------------------------------------------------------
module tb_node_rx_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int ADDR  = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] din = '0;
   logic          inv = 1'b0;
   logic          ready = 1'b0;
   logic          clr_flags = 1'b0;

   logic [DW-1:0] dout     [4];
   logic [1:0]    dout_src [4];
   logic          outv     [4];
   logic [ADDR:0] count    [4];
   logic          full     [4];
   logic          empty    [4];
   logic          overflow [4];
   logic          self_err [4];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      node_rx_fifo #(
         .data_len (DW),
         .DEPTH    (DEPTH),
         .ADDR     (ADDR),
         .NODE_ID  (g)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .din       (din),
         .inv       (inv),
         .dout      (dout[g]),
         .dout_src  (dout_src[g]),
         .outv      (outv[g]),
         .ready     (ready),
         .count     (count[g]),
         .full      (full[g]),
         .empty     (empty[g]),
         .overflow  (overflow[g]),
         .self_err  (self_err[g]),
         .clr_flags (clr_flags)
      );
   end

   int checks = 0;
   int errors = 0;

   // Reference model: one queue of {src, data} per node, edges since reset
   logic [9:0]  mq [4][$];
   bit          m_ovf  [4];
   bit          m_serr [4];
   int unsigned cyc;

   task automatic chk(input string name, input int n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s node%0d: got %0h expected %0h (t=%0t)", name, n, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int n = 0; n < 4; n++) begin
         mq[n].delete();
         m_ovf[n]  = 1'b0;
         m_serr[n] = 1'b0;
      end
      cyc = 0;
   endtask

   // Applies one clock edge of the rules to the model using pre-edge inputs
   task automatic model_edge();
      int src;
      bit pop;
      bit self_slot;
      src = (cyc + 3) % 4;
      for (int n = 0; n < 4; n++) begin
         pop       = (mq[n].size() > 0) && ready;
         self_slot = inv && (src == n);
         if (clr_flags) begin
            m_ovf[n]  = 1'b0;
            m_serr[n] = 1'b0;
         end
         if (pop) void'(mq[n].pop_front());
         if (inv && !self_slot) begin
            if (mq[n].size() < DEPTH) mq[n].push_back({src[1:0], din});
            else                      m_ovf[n] = 1'b1;
         end
         if (self_slot) m_serr[n] = 1'b1;
      end
      cyc++;
   endtask

   task automatic check_model();
      int c;
      for (int n = 0; n < 4; n++) begin
         c = mq[n].size();
         chk("m_count", n, 32'(count[n]), 32'(c));
         chk("m_empty", n, 32'(empty[n]), 32'(c == 0));
         chk("m_full",  n, 32'(full[n]),  32'(c == DEPTH));
         chk("m_outv",  n, 32'(outv[n]),  32'(c != 0));
         chk("m_ovf",   n, 32'(overflow[n]), 32'(m_ovf[n]));
         chk("m_serr",  n, 32'(self_err[n]), 32'(m_serr[n]));
         if (c != 0) begin
            chk("m_dout", n, 32'(dout[n]),     32'(mq[n][0][7:0]));
            chk("m_src",  n, 32'(dout_src[n]), 32'(mq[n][0][9:8]));
         end
      end
   endtask

   task automatic step(input bit i_inv, input logic [7:0] i_din, input bit i_rdy,
                       input bit i_clr);
      inv       = i_inv;
      din       = i_din;
      ready     = i_rdy;
      clr_flags = i_clr;
      model_edge();
      @(posedge clk);
      #1;
      check_model();
   endtask

   // Asserts reset between edges and checks the async effect before any edge
   task automatic do_reset();
      inv       = 1'b0;
      ready     = 1'b0;
      clr_flags = 1'b0;
      reset     = 1'b0;
      #1;
      for (int n = 0; n < 4; n++) begin
         chk("rst_count", n, 32'(count[n]),    32'd0);
         chk("rst_empty", n, 32'(empty[n]),    32'd1);
         chk("rst_full",  n, 32'(full[n]),     32'd0);
         chk("rst_outv",  n, 32'(outv[n]),     32'd0);
         chk("rst_dout",  n, 32'(dout[n]),     32'd0);
         chk("rst_src",   n, 32'(dout_src[n]), 32'd0);
         chk("rst_ovf",   n, 32'(overflow[n]), 32'd0);
         chk("rst_serr",  n, 32'(self_err[n]), 32'd0);
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
   endtask

   typedef struct {
      bit         rst;
      bit         inv;
      logic [7:0] din;
      bit         rdy;
      bit         clr;
      int         node;
      int         cnt;
      bit         ov;
      logic [7:0] d;
      logic [1:0] s;
      bit         ovf;
      bit         serr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(bit rst, bit i_inv, logic [7:0] i_din, bit rdy, bit clr,
                              int node, int cnt, bit ov, logic [7:0] d, logic [1:0] s,
                              bit ovf, bit serr);
      vec_t r;
      r.rst = rst; r.inv = i_inv; r.din = i_din; r.rdy = rdy; r.clr = clr;
      r.node = node; r.cnt = cnt; r.ov = ov; r.d = d; r.s = s;
      r.ovf = ovf; r.serr = serr;
      return r;
   endfunction

   initial begin
      // Alignment, NODE_ID=1: word on edge 2 (slot 1) is tagged node 0
      tbl.push_back(v(1, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'hA5, 0, 0, 1, 1, 1, 8'hA5, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 1, 1, 1, 8'hA5, 0, 0, 0));
      // Round-robin, NODE_ID=0: slots 2,3,0 then drain in order
      tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h11, 0, 0, 0, 1, 1, 8'h11, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h22, 0, 0, 0, 2, 1, 8'h11, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h33, 0, 0, 0, 3, 1, 8'h11, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 2, 1, 8'h22, 2, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h33, 3, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      // Overflow, NODE_ID=0: fifth word dropped, then clr_flags
      tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h01, 0, 0, 0, 1, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h02, 0, 0, 0, 2, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h03, 0, 0, 0, 3, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 3, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h04, 0, 0, 0, 4, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h05, 0, 0, 0, 4, 1, 8'h01, 1, 1, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 3, 1, 8'h02, 2, 1, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 2, 1, 8'h03, 3, 1, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h04, 1, 1, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 1, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0));
      // Full with simultaneous push and pop, NODE_ID=0
      tbl.push_back(v(1, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h01, 0, 0, 0, 1, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h02, 0, 0, 0, 2, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h03, 0, 0, 0, 3, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 0, 3, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h04, 0, 0, 0, 4, 1, 8'h01, 1, 0, 0));
      tbl.push_back(v(0, 1, 8'h05, 1, 0, 0, 4, 1, 8'h02, 2, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 3, 1, 8'h03, 3, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 2, 1, 8'h04, 1, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 1, 1, 8'h05, 2, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00, 0, 0, 0));
      // Self slot, NODE_ID=2: slot 3 words rejected, set beats clear
      tbl.push_back(v(1, 0, 8'h00, 0, 0, 2, 0, 0, 8'h00, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h66, 0, 0, 2, 1, 1, 8'h66, 0, 0, 0));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 2, 1, 1, 8'h66, 0, 0, 0));
      tbl.push_back(v(0, 1, 8'h77, 0, 0, 2, 1, 1, 8'h66, 0, 0, 1));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 2, 1, 1, 8'h66, 0, 0, 1));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 2, 1, 1, 8'h66, 0, 0, 1));
      tbl.push_back(v(0, 0, 8'h00, 0, 0, 2, 1, 1, 8'h66, 0, 0, 1));
      tbl.push_back(v(0, 1, 8'h88, 0, 1, 2, 1, 1, 8'h66, 0, 0, 1));
      tbl.push_back(v(0, 0, 8'h00, 0, 1, 2, 1, 1, 8'h66, 0, 0, 0));

      @(negedge clk);
      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         step(tbl[i].inv, tbl[i].din, tbl[i].rdy, tbl[i].clr);
         chk("t_count", tbl[i].node, 32'(count[tbl[i].node]),    32'(tbl[i].cnt));
         chk("t_full",  tbl[i].node, 32'(full[tbl[i].node]),     32'(tbl[i].cnt == DEPTH));
         chk("t_outv",  tbl[i].node, 32'(outv[tbl[i].node]),     32'(tbl[i].ov));
         chk("t_ovf",   tbl[i].node, 32'(overflow[tbl[i].node]), 32'(tbl[i].ovf));
         chk("t_serr",  tbl[i].node, 32'(self_err[tbl[i].node]), 32'(tbl[i].serr));
         if (tbl[i].ov) begin
            chk("t_dout", tbl[i].node, 32'(dout[tbl[i].node]),     32'(tbl[i].d));
            chk("t_src",  tbl[i].node, 32'(dout_src[tbl[i].node]), 32'(tbl[i].s));
         end
      end

      // Async reset mid-stream: node 0 holds 3 words and a set self_err
      do_reset();
      step(0, 8'h00, 0, 0);
      step(1, 8'h5A, 0, 0);
      step(1, 8'hC1, 0, 0);
      step(1, 8'hC2, 0, 0);
      step(1, 8'hC3, 0, 0);
      chk("pre_rst_count", 0, 32'(count[0]),    32'd3);
      chk("pre_rst_serr",  0, 32'(self_err[0]), 32'd1);
      chk("pre_rst_dout",  0, 32'(dout[0]),     32'hC1);
      do_reset();
      // Slot counter restarted: alignment holds again
      step(0, 8'h00, 0, 0);
      step(1, 8'hA5, 0, 0);
      chk("realign_outv", 1, 32'(outv[1]),     32'd1);
      chk("realign_dout", 1, 32'(dout[1]),     32'hA5);
      chk("realign_src",  1, 32'(dout_src[1]), 32'd0);
      chk("realign_cnt",  1, 32'(count[1]),    32'd1);

      // Random traffic against the model, with occasional resets
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) do_reset();
         step($urandom_range(0, 99) < 60, 8'($urandom), 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
